// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer slice.
// Holds the opcodes, the FSM state encoding and the default operand width.
package alu_seq_pkg;

    localparam int ALU_DATA_W = 4;

    localparam logic [2:0] OP_PAR   = 3'd0;
    localparam logic [2:0] OP_RCA   = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_ORXOR = 3'd3;
    localparam logic [2:0] OP_RED   = 3'd4;
    localparam logic [2:0] OP_CAT   = 3'd5;
    localparam logic [2:0] OP_MUL   = 3'd6;
    localparam logic [2:0] OP_BAD   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Command/result handshake bundle between a driver and the sequencer.
// Ports: in_* command channel (valid/ready), out_* result channel (valid/ready).
interface alu_sequencer_if
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            in_op;
    logic [DATA_W-1:0]     in_a;
    logic [DATA_W-1:0]     in_b;
    logic                  in_use_acc;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*DATA_W-1:0]   out_data;
    logic                  out_err;

    modport master (
        output in_valid, in_op, in_a, in_b, in_use_acc, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_use_acc, out_ready,
        output in_ready, out_valid, out_data, out_err
    );

endinterface

// File: rtl/alu_core.sv
// Combinational nibble ALU for every opcode except the multiply.
// Ports: op/a/b in; res (2*DATA_W) and err (invalid opcode) out.
module alu_core
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic [2:0]          op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [2*DATA_W-1:0] res,
    output logic                err
);

    logic [DATA_W-1:0] rca_sum;
    logic              rca_cout;

    // Explicit bit-serial carry chain, kept distinct from the '+' op.
    always_comb begin
        logic carry;
        carry   = 1'b0;
        rca_sum = '0;
        for (int i = 0; i < DATA_W; i++) begin
            rca_sum[i] = a[i] ^ b[i] ^ carry;
            carry      = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        rca_cout = carry;
    end

    always_comb begin
        res = '0;
        err = 1'b0;
        unique case (op)
            OP_PAR:   res = {{(2*DATA_W-1){1'b0}}, (~^a) & (~^b)};
            OP_RCA:   res = {{(DATA_W-1){1'b0}}, rca_cout, rca_sum};
            OP_ADD:   res = {{DATA_W{1'b0}}, a} + {{DATA_W{1'b0}}, b};
            OP_ORXOR: res = {a | b, a ^ b};
            OP_RED:   res = {{(2*DATA_W-1){1'b0}}, |{a, b}};
            OP_CAT:   res = {a, b};
            OP_MUL:   res = '0;
            OP_BAD: begin
                res = '0;
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU controller: accepts commands, runs ALU or shift-add MUL.
// Ports: clk, reset (sync, active-high), bus (slave), acc, op_count.
// Optional: define ALU_SEQ_OPCOUNT_EN to build the saturating op_count.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W    = ALU_DATA_W,
    parameter int MUL_STEPS = ALU_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_sequencer_if.slave        bus,
    output logic [2*DATA_W-1:0]   acc,
    output logic [7:0]            op_count
);

    localparam int STEP_W = $clog2(MUL_STEPS + 1);

    state_t state_q, state_d;

    logic [2:0]           op_q;
    logic [DATA_W-1:0]    a_q;
    logic [DATA_W-1:0]    b_q;
    logic [2*DATA_W-1:0]  prod_q;
    logic [2*DATA_W-1:0]  mcand_q;
    logic [DATA_W-1:0]    mplier_q;
    logic [STEP_W-1:0]    step_q;
    logic [2*DATA_W-1:0]  out_data_q;
    logic                 out_err_q;

    logic [2*DATA_W-1:0]  core_res;
    logic                 core_err;
    logic [2*DATA_W-1:0]  prod_next;
    logic                 mul_last;
    logic                 done_hs;

    alu_core #(.DATA_W(DATA_W)) u_core (
        .op  (op_q),
        .a   (a_q),
        .b   (b_q),
        .res (core_res),
        .err (core_err)
    );

    // mcand_q is shifted left each step, so it already equals A<<step.
    assign prod_next = mplier_q[0] ? prod_q + mcand_q : prod_q;
    assign mul_last  = (step_q == STEP_W'(MUL_STEPS - 1));
    assign done_hs   = (state_q == S_DONE) && bus.out_ready;

    // Handshake outputs depend on state only: no out_ready->in_ready path.
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (bus.in_valid) state_d = S_EXEC;
            S_EXEC: state_d = (op_q == OP_MUL) ? S_MUL : S_DONE;
            S_MUL:  if (mul_last) state_d = S_DONE;
            S_DONE: if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            prod_q     <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            step_q     <= '0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
            acc        <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        op_q <= bus.in_op;
                        a_q  <= bus.in_a;
                        b_q  <= bus.in_use_acc ? acc[DATA_W-1:0]
                                               : bus.in_b;
                    end
                end
                S_EXEC: begin
                    if (op_q == OP_MUL) begin
                        prod_q   <= '0;
                        mcand_q  <= {{DATA_W{1'b0}}, a_q};
                        mplier_q <= b_q;
                        step_q   <= '0;
                    end else begin
                        out_data_q <= core_res;
                        out_err_q  <= core_err;
                        acc        <= core_res;
                    end
                end
                S_MUL: begin
                    prod_q   <= prod_next;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    step_q   <= step_q + 1'b1;
                    if (mul_last) begin
                        out_data_q <= prod_next;
                        out_err_q  <= 1'b0;
                        acc        <= prod_next;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_SEQ_OPCOUNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            op_count <= 8'd0;
        else if (done_hs && (op_count != 8'hFF))
            op_count <= op_count + 8'd1;
    end
`else
    assign op_count = 8'd0;
    logic unused_hs;
    assign unused_hs = done_hs;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: vector table plus scoreboard.
// Hand sequences cover backpressure, reset mid-MUL and op_count.
module tb_alu_sequencer;

    logic clk;
    logic reset;
    logic [7:0] acc;
    logic [7:0] op_count;

    alu_sequencer_if #(.DATA_W(4)) bus ();

    alu_sequencer #(.DATA_W(4), .MUL_STEPS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .acc      (acc),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ALU_SEQ_OPCOUNT_EN
    localparam bit OPC_EN = 1'b1;
`else
    localparam bit OPC_EN = 1'b0;
`endif

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       ua;
        logic [7:0] d;
        logic       e;
        int         lat;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       e;
    } exp_t;

    vec_t vt[14];
    exp_t sb[$];
    int   checks;
    int   errors;
    int   hs;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({name, "_data"}, {24'd0, bus.out_data}, {24'd0, e.d});
            check({name, "_err"}, {31'd0, bus.out_err}, {31'd0, e.e});
            check({name, "_acc"}, {24'd0, acc}, {24'd0, e.d});
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic ua,
                        input logic [7:0] d, input logic e,
                        input int lat, input string name);
        int cyc;
        bit seen;
        exp_t x;
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.in_op      = op;
        bus.in_a       = a;
        bus.in_b       = b;
        bus.in_use_acc = ua;
        cyc = 0;
        while (!bus.in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_accept"}, {31'd0, bus.in_ready}, 32'd1);
        x.d = d;
        x.e = e;
        sb.push_back(x);
        @(negedge clk);
        bus.in_valid = 1'b0;
        cyc  = 1;
        seen = 1'b0;
        while (!bus.in_ready && cyc < 30) begin
            if (bus.out_valid && !seen) begin
                seen = 1'b1;
                check({name, "_lat"}, cyc, lat);
                pop_check(name);
            end
            @(negedge clk);
            cyc++;
        end
        check({name, "_seen"}, {31'd0, seen}, 32'd1);
        check({name, "_busy"}, cyc - 1, lat);
        check({name, "_vld_drop"}, {31'd0, bus.out_valid}, 32'd0);
        if (seen) hs++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int exp_cnt;
        logic [3:0] ra, rb;
        checks = 0;
        errors = 0;
        hs     = 0;

        vt[0]  = '{3'd3, 4'hA, 4'h6, 1'b0, 8'hEC, 1'b0, 2};
        vt[1]  = '{3'd1, 4'h9, 4'h8, 1'b0, 8'h11, 1'b0, 2};
        vt[2]  = '{3'd2, 4'h3, 4'hF, 1'b1, 8'h04, 1'b0, 2};
        vt[3]  = '{3'd6, 4'hF, 4'hF, 1'b0, 8'hE1, 1'b0, 6};
        vt[4]  = '{3'd6, 4'h0, 4'h7, 1'b0, 8'h00, 1'b0, 6};
        vt[5]  = '{3'd0, 4'h3, 4'h5, 1'b0, 8'h01, 1'b0, 2};
        vt[6]  = '{3'd0, 4'h1, 4'h5, 1'b0, 8'h00, 1'b0, 2};
        vt[7]  = '{3'd7, 4'h5, 4'h5, 1'b0, 8'h00, 1'b1, 2};
        vt[8]  = '{3'd4, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 2};
        vt[9]  = '{3'd4, 4'h0, 4'h1, 1'b0, 8'h01, 1'b0, 2};
        vt[10] = '{3'd5, 4'hC, 4'h3, 1'b0, 8'hC3, 1'b0, 2};
        vt[11] = '{3'd1, 4'hF, 4'hF, 1'b0, 8'h1E, 1'b0, 2};
        vt[12] = '{3'd6, 4'h3, 4'h0, 1'b1, 8'h2A, 1'b0, 6};
        vt[13] = '{3'd6, 4'hD, 4'hB, 1'b0, 8'h8F, 1'b0, 6};

        bus.in_valid   = 1'b0;
        bus.in_op      = 3'd0;
        bus.in_a       = 4'd0;
        bus.in_b       = 4'd0;
        bus.in_use_acc = 1'b0;
        bus.out_ready  = 1'b1;
        reset          = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_data", {24'd0, bus.out_data}, 32'd0);
        check("rst_out_err", {31'd0, bus.out_err}, 32'd0);
        check("rst_acc", {24'd0, acc}, 32'd0);
        check("rst_op_count", {24'd0, op_count}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++)
            send(vt[i].op, vt[i].a, vt[i].b, vt[i].ua,
                 vt[i].d, vt[i].e, vt[i].lat, $sformatf("vec%0d", i));

        @(negedge clk);
        exp_cnt = OPC_EN ? hs : 0;
        check("opcnt_table", {24'd0, op_count}, exp_cnt);

        // Backpressure: result held, next command waits for handshake.
        bus.out_ready  = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_op      = 3'd5;
        bus.in_a       = 4'h5;
        bus.in_b       = 4'hA;
        bus.in_use_acc = 1'b0;
        check("bp_ready0", {31'd0, bus.in_ready}, 32'd1);
        sb.push_back('{8'h5A, 1'b0});
        @(negedge clk);
        bus.in_op = 3'd3;
        bus.in_a  = 4'h1;
        bus.in_b  = 4'h2;
        for (int c = 0; c < 10 && !bus.out_valid; c++) @(negedge clk);
        check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
        pop_check("bp_first");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_hold_vld", {31'd0, bus.out_valid}, 32'd1);
            check("bp_hold_data", {24'd0, bus.out_data}, 32'h5A);
            check("bp_hold_acc", {24'd0, acc}, 32'h5A);
            check("bp_hold_rdy", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        sb.push_back('{8'h33, 1'b0});
        @(negedge clk);
        hs++;
        check("bp_hs_vld", {31'd0, bus.out_valid}, 32'd0);
        check("bp_hs_rdy", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_next_exec", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        check("bp_next_vld", {31'd0, bus.out_valid}, 32'd1);
        pop_check("bp_second");
        hs++;
        @(negedge clk);

        // Reset during MUL step 2 discards the multiply.
        bus.in_valid = 1'b1;
        bus.in_op    = 3'd6;
        bus.in_a     = 4'h7;
        bus.in_b     = 4'h5;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mrst_acc", {24'd0, acc}, 32'd0);
        check("mrst_op_count", {24'd0, op_count}, 32'd0);
        reset = 1'b0;
        hs = 0;
        sb.delete();

        for (int i = 0; i < 300; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            send(3'd5, ra, rb, 1'b0, {ra, rb}, 1'b0, 2, "bulk");
        end
        @(negedge clk);
        exp_cnt = OPC_EN ? ((hs > 255) ? 255 : hs) : 0;
        check("opcnt_sat", {24'd0, op_count}, exp_cnt);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
